song_note_player: RTL and testbench
===================================

Name: song_note_player

Overview:
- Sits directly downstream of the debounced mode/song counter and consumes its 2-bit count.
- Count 0 means stop/silent; 1 plays song A; 2 plays song B; 3 is treated as silent.
- Steps through a 16-note ROM per song and drives a square-wave buzzer at each note's pitch. The song loops until the selection changes.

Parameters:
- NOTE_CYCLES, 25_000_000: clock cycles per note slot (0.25 s at 100 MHz).
- GAP_CYCLES, 2_500_000: silent cycles at the end of every note slot, for articulation. Must be < NOTE_CYCLES.
- TONE_SHIFT, 0: right-shift applied to ROM half-periods. Simulation only; production uses 0.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous reset, active-high
- song_sel  input  2  song selection from the button counter; stable between presses
- buzzer  output  1  square-wave audio output
- playing  output  1  high while in PLAY state
- note_idx  output  4  current note slot, 0..15
- note_code  output  3  current note code, 0 = rest

Behaviour:
- Reset values, with rst sampled on the clk edge:
  - buzzer = 0, playing = 0, note_idx = 0, note_code = 0.
  - State = IDLE; sel_q = 0; all counters = 0.
- Note codes:
  - 0 = rest; 1..7 = C4 D4 E4 F4 G4 A4 B4.
  - Half-periods at 100 MHz: 191113, 170265, 151686, 143172, 127551, 113636, 101239 (18-bit).
  - Effective half-period: half = rom_half >> TONE_SHIFT, forced to at least 1.
- Song A (sel = 1): C D E C C D E C E F G rest E F G rest.
- Song B (sel = 2): C C G G A A G rest F F E E D D C rest.
- Selection register: sel_q <= song_sel every cycle. A change is detected when song_sel != sel_q.
- On a change, at that edge:
  - note_idx = 0, note_cnt = 0, tone_cnt = 0, buzzer = 0.
  - Next state = PLAY if song_sel is 1 or 2, else IDLE.
  - playing reflects the new state on the following cycle.
- State IDLE:
  - Counters are held at 0; buzzer = 0; note_code = 0.
- State PLAY:
  - note_code = ROM[sel_q][note_idx], registered combinationally from the current index.
  - note_cnt increments each cycle.
  - When note_cnt == NOTE_CYCLES-1: note_cnt = 0, note_idx = note_idx+1 (wraps 15 -> 0), tone_cnt = 0, buzzer = 0. Each new note starts phase-aligned, low.
  - Tone phase applies when note_code != 0 and note_cnt < NOTE_CYCLES-GAP_CYCLES:
    - tone_cnt increments each cycle.
    - When tone_cnt == half-1: tone_cnt = 0 and buzzer toggles.
  - Rest or gap phase: buzzer = 0, tone_cnt = 0.
- Priority: rst > selection change > note boundary > tone toggle.
- Reset mid-note returns to IDLE immediately, regardless of song_sel. On the next cycle sel_q = song_sel (register reloads from 0), so a nonzero sel then triggers a change and starts the song from note 0.
- Arithmetic widths:
  - note_cnt is $clog2(NOTE_CYCLES) bits.
  - tone_cnt and half are 18 bits, unsigned, no saturation needed.

Decomposition:
- Package song_pkg holds:
  - note code localparams (NOTE_REST, NOTE_C4 .. NOTE_B4);
  - the half-period constant function;
  - the song A / song B ROM contents as functions indexed by note_idx.
- One sub-module, tone_gen. Inputs: clk, rst, clear, enable, half. Output: buzzer. It encapsulates tone_cnt and the toggle logic.
- The parent owns the FSM, the note timer and the ROM lookup.

Test Plan (NOTE_CYCLES = 64, GAP_CYCLES = 8, TONE_SHIFT = 14, so C = 11, D = 10, E = 9, G = 7 cycles per half-period):
- Reset: assert rst 3 cycles with song_sel = 1, release -> buzzer = 0, playing = 0 during reset. One cycle after release the change is detected; then playing = 1, note_idx = 0, note_code = 1.
- Song A note 0: buzzer toggles every 11 cycles for the first 56 cycles of the slot, then stays 0 for 8 cycles. At slot end note_idx = 1, note_code = 2, and toggles occur every 10 cycles.
- Rest and wrap: run song A to note_idx 15 (code 0) -> buzzer stays 0 for all 64 cycles. Then note_idx wraps to 0 with note_code = 1.
- Song change mid-note: switch song_sel 1 -> 2 at note_idx 5, mid-tone -> next edge gives note_idx = 0, buzzer = 0. Then song B C, C (two slots with the gap between), then G at 7-cycle toggles.
- Stop: song_sel 2 -> 0 mid-note -> playing = 0 one cycle later, buzzer = 0, note_idx = 0, and all held. Setting song_sel = 3 also keeps IDLE.
- Reset mid-play: assert rst at note_idx 3 -> IDLE and all outputs 0 at that edge. Release with song_sel = 2 -> restarts from note 0 of song B.

Source files
------------

// File: rtl/song_note_player_pkg.sv
// song_pkg: note codes, pitch half-periods and the two 16-note song ROMs
package song_pkg;
  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C4 = 3'd1;
  localparam logic [2:0] NOTE_D4 = 3'd2;
  localparam logic [2:0] NOTE_E4 = 3'd3;
  localparam logic [2:0] NOTE_F4 = 3'd4;
  localparam logic [2:0] NOTE_G4 = 3'd5;
  localparam logic [2:0] NOTE_A4 = 3'd6;
  localparam logic [2:0] NOTE_B4 = 3'd7;
  // ROM images, note 15 in the top bits down to note 0 in the bottom bits
  localparam logic [47:0] SONG_A = {NOTE_REST, NOTE_G4, NOTE_F4, NOTE_E4, NOTE_REST, NOTE_G4, NOTE_F4, NOTE_E4,
                                    NOTE_C4, NOTE_E4, NOTE_D4, NOTE_C4, NOTE_C4, NOTE_E4, NOTE_D4, NOTE_C4};
  localparam logic [47:0] SONG_B = {NOTE_REST, NOTE_C4, NOTE_D4, NOTE_D4, NOTE_E4, NOTE_E4, NOTE_F4, NOTE_F4,
                                    NOTE_REST, NOTE_G4, NOTE_A4, NOTE_A4, NOTE_G4, NOTE_G4, NOTE_C4, NOTE_C4};
  function automatic logic [17:0] half_period(input logic [2:0] code);
    return code == NOTE_C4 ? 18'd191113 :
           code == NOTE_D4 ? 18'd170265 :
           code == NOTE_E4 ? 18'd151686 :
           code == NOTE_F4 ? 18'd143172 :
           code == NOTE_G4 ? 18'd127551 :
           code == NOTE_A4 ? 18'd113636 :
           code == NOTE_B4 ? 18'd101239 : 18'd0;
  endfunction
  function automatic logic [2:0] song_a(input logic [3:0] i);
    return SONG_A[3*i +: 3];
  endfunction
  function automatic logic [2:0] song_b(input logic [3:0] i);
    return SONG_B[3*i +: 3];
  endfunction
endpackage

// File: rtl/song_note_player_tone_gen.sv
// tone_gen: square-wave generator toggling every 'half' enabled cycles
// ports: clk, rst (sync, active-high), clear (restart low), enable (count), half (cycles per level), buzzer (output)
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [17:0] half,
  output logic        buzzer
);
  logic [17:0] tone_cnt;
  always_ff @(posedge clk)
    if (rst || clear) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (enable) begin
      tone_cnt <= tone_cnt == half - 18'd1 ? '0 : tone_cnt + 18'd1;
      buzzer   <= tone_cnt == half - 18'd1 ? ~buzzer : buzzer;
    end
endmodule

// File: rtl/song_note_player.sv
// song_note_player: plays song A or B from the song counter as a looping square-wave melody
// ports: clk, rst (sync, active-high), song_sel (0/3 silent, 1 song A, 2 song B),
//        buzzer (audio), playing (in PLAY), note_idx (slot 0..15), note_code (0 = rest)
module song_note_player
  import song_pkg::*;
#(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int TONE_SHIFT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] song_sel,
  output logic       buzzer,
  output logic       playing,
  output logic [3:0] note_idx,
  output logic [2:0] note_code
);
  localparam int NW = $clog2(NOTE_CYCLES);
  localparam logic [NW-1:0] LAST = NW'(NOTE_CYCLES - 1);
  localparam logic [NW-1:0] TONE_END = NW'(NOTE_CYCLES - GAP_CYCLES);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state;
  logic [1:0] sel_q;
  logic [NW-1:0] note_cnt;
  logic change, last, tone_on;
  logic [17:0] rom_half, half;
  assign change = song_sel != sel_q;
  assign last = note_cnt == LAST;
  assign playing = state == PLAY;
  assign note_code = state == PLAY ? (sel_q == 2'd2 ? song_b(note_idx) : song_a(note_idx)) : NOTE_REST;
  assign rom_half = half_period(note_code) >> TONE_SHIFT;
  assign half = rom_half == '0 ? 18'd1 : rom_half;
  // the tone runs only inside the sounding part of a non-rest slot; anything else restarts it low
  assign tone_on = state == PLAY && !change && !last && note_code != NOTE_REST && note_cnt < TONE_END;
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      note_idx <= 4'd0;
      note_cnt <= '0;
    end else begin
      sel_q <= song_sel;
      if (change) begin
        state    <= song_sel == 2'd1 || song_sel == 2'd2 ? PLAY : IDLE;
        note_idx <= 4'd0;
        note_cnt <= '0;
      end else if (state == PLAY) begin
        note_cnt <= last ? '0 : note_cnt + NW'(1);
        note_idx <= last ? note_idx + 4'd1 : note_idx;
      end
    end
  tone_gen u_tone (
    .clk    (clk),
    .rst    (rst),
    .clear  (!tone_on),
    .enable (tone_on),
    .half   (half),
    .buzzer (buzzer)
  );
endmodule

// File: tb/tb_song_note_player.sv
// tb_song_note_player: directed self-checking bench for song_note_player with shortened timing
module tb_song_note_player;
  localparam int NC = 64;
  localparam int GC = 8;
  localparam int TONE_END = NC - GC;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] song_sel;
  logic buzzer, playing;
  logic [3:0] note_idx;
  logic [2:0] note_code;
  int n_chk = 0;
  int n_fail = 0;
  int halves[8] = '{1, 11, 10, 9, 8, 7, 6, 6};
  int song_a[16] = '{1, 2, 3, 1, 1, 2, 3, 1, 3, 4, 5, 0, 3, 4, 5, 0};
  int song_b[16] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};
  song_note_player #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .TONE_SHIFT(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .song_sel  (song_sel),
    .buzzer    (buzzer),
    .playing   (playing),
    .note_idx  (note_idx),
    .note_code (note_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      chk("idle_playing", 32'(playing), 0);
      chk("idle_buzzer", 32'(buzzer), 0);
      chk("idle_note_idx", 32'(note_idx), 0);
      chk("idle_note_code", 32'(note_code), 0);
      step();
    end
  endtask
  // k counts cycles from the start of the slot; the level flips every 'half' cycles during the sounding part
  task automatic slot(input int idx, input int code, input int n);
    int hp, exp_bz;
    hp = halves[code];
    for (int k = 0; k < n; k++) begin
      exp_bz = (code != 0 && k <= TONE_END) ? (k / hp) % 2 : 0;
      chk("play_playing", 32'(playing), 1);
      chk("play_note_idx", 32'(note_idx), 32'(idx));
      chk("play_note_code", 32'(note_code), 32'(code));
      chk("play_buzzer", 32'(buzzer), 32'(exp_bz));
      step();
    end
  endtask
  initial begin
    rst = 1'b1;
    song_sel = 2'd1;
    step();
    idle(3);
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) slot(i, song_a[i], NC);
    for (int i = 0; i < 5; i++) slot(i, song_a[i], NC);
    slot(5, song_a[5], 15);
    chk("mid_tone_high", 32'(buzzer), 1);
    song_sel = 2'd2;
    step();
    for (int i = 0; i < 3; i++) slot(i, song_b[i], NC);
    slot(3, song_b[3], 20);
    song_sel = 2'd0;
    step();
    idle(40);
    song_sel = 2'd3;
    idle(40);
    song_sel = 2'd2;
    step();
    for (int i = 0; i < 3; i++) slot(i, song_b[i], NC);
    slot(3, song_b[3], 10);
    rst = 1'b1;
    step();
    idle(2);
    rst = 1'b0;
    step();
    slot(0, song_b[0], NC);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
